// File: rtl/skew_feed_hs.sv
// Systolic edge skewer: one M-lane vector per handshake; lane i emitted after D(i) steps.
// Latency D(i) = REVERSE ? M-i : i+1 cycles; out_done pulses M cycles after the last fire.
// Backpressure: hold freezes everything; in_ready drops during hold, flush and drain.
module skew_feed_hs #(
    parameter int M       = 3,
    parameter int DW      = 8,
    parameter int REVERSE = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            flush,
    input  logic            hold,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [M*DW-1:0] in_data,
    output logic [M*DW-1:0] out_data,
    output logic [M-1:0]    out_valid,
    output logic            out_done,
    output logic            busy
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            step;
    logic            fire;
    logic            done_nxt;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    lane_busy;

    assign step = !hold && !flush;
    assign fire = in_valid && in_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else if (step) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, STREAM: begin
                if (fire) begin
                    if (!in_last)   state_nxt = STREAM;
                    else if (M > 1) state_nxt = DRAIN;
                    else            state_nxt = IDLE;
                end
            end
            DRAIN:   if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A single-stage build has nothing to drain, so the last fire completes immediately.
    always_comb begin
        in_ready = !hold && !flush && (state != DRAIN);
        done_nxt = step && (((state == DRAIN) && (cnt == CW'(1))) ||
                            ((M == 1) && fire && in_last));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            out_done <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            out_done <= 1'b0;
        end else begin
            out_done <= done_nxt;
            if (step) begin
                if (fire && in_last)    cnt <= CW'(M - 1);
                else if (state == DRAIN) cnt <= cnt - CW'(1);
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        localparam int D = (REVERSE != 0) ? (M - i) : (i + 1);

        logic [DW-1:0] dat [D];
        logic [D-1:0]  vld;

        // Bubbles load zero data so downstream accumulators see a neutral operand.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int s = 0; s < D; s++) dat[s] <= '0;
                vld <= '0;
            end else if (flush) begin
                for (int s = 0; s < D; s++) dat[s] <= '0;
                vld <= '0;
            end else if (step) begin
                dat[0] <= fire ? in_data[DW*i +: DW] : '0;
                vld[0] <= fire;
                for (int s = 1; s < D; s++) begin
                    dat[s] <= dat[s-1];
                    vld[s] <= vld[s-1];
                end
            end
        end

        assign out_data[DW*i +: DW] = dat[D-1];
        assign out_valid[i]         = vld[D-1];
        assign lane_busy[i]         = |vld;
    end

    assign busy = (state != IDLE) || (|lane_busy);

endmodule

// File: tb/tb_skew_feed_hs.sv
// Bench for skew_feed_hs: three builds (M=3 forward, M=3 reverse, M=1) share one stimulus
// stream and are checked against a queue-based delay-line model plus directed sequences.
module tb_skew_feed_hs;

    logic        CLK = 1'b0;
    logic        RST_N, flush, hold, in_valid, in_last;
    logic [23:0] in_data;

    logic [23:0] od0, od1;
    logic [7:0]  od2;
    logic [2:0]  ov0, ov1;
    logic        ov2;
    logic        rd0, rd1, rd2, dn0, dn1, dn2, bz0, bz1, bz2;

    always #5 CLK = ~CLK;

    skew_feed_hs #(.M(3), .DW(8), .REVERSE(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .hold(hold), .in_valid(in_valid),
        .in_ready(rd0), .in_last(in_last), .in_data(in_data), .out_data(od0),
        .out_valid(ov0), .out_done(dn0), .busy(bz0));

    skew_feed_hs #(.M(3), .DW(8), .REVERSE(1)) dut_r (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .hold(hold), .in_valid(in_valid),
        .in_ready(rd1), .in_last(in_last), .in_data(in_data), .out_data(od1),
        .out_valid(ov1), .out_done(dn1), .busy(bz1));

    skew_feed_hs #(.M(1), .DW(8), .REVERSE(0)) dut_1 (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .hold(hold), .in_valid(in_valid),
        .in_ready(rd2), .in_last(in_last), .in_data(in_data[7:0]), .out_data(od2),
        .out_valid(ov2), .out_done(dn2), .busy(bz2));

    logic [23:0] a_dat [3];
    logic [2:0]  a_vld [3];
    logic        a_done [3], a_rdy [3], a_busy [3];

    always_comb begin
        a_dat[0] = od0; a_dat[1] = od1; a_dat[2] = {16'h0, od2};
        a_vld[0] = ov0; a_vld[1] = ov1; a_vld[2] = {2'b00, ov2};
        a_done[0] = dn0; a_done[1] = dn1; a_done[2] = dn2;
        a_rdy[0] = rd0; a_rdy[1] = rd1; a_rdy[2] = rd2;
        a_busy[0] = bz0; a_busy[1] = bz1; a_busy[2] = bz2;
    end

    // Model: each config keeps the sequence of stage-0 loads; lane output = entry at its delay.
    typedef struct packed {
        logic [23:0] dat;
        logic        vld;
        logic        last;
    } ent_t;

    ent_t hq [3][$];
    bit   in_stream [3];
    bit   prev_step [3];
    int   mm [3] = '{3, 3, 1};
    int   rv [3] = '{0, 1, 0};
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic ent_t at_d(int c, int d);
        ent_t e = '0;
        if (d >= 1 && hq[c].size() >= d) e = hq[c][hq[c].size() - d];
        return e;
    endfunction

    function automatic bit draining(int c);
        bit r = 1'b0;
        for (int d = 1; d < mm[c]; d++) begin
            ent_t e = at_d(c, d);
            if (e.vld && e.last) r = 1'b1;
        end
        return r;
    endfunction

    function automatic bit exp_ready(int c);
        return !hold && !flush && !draining(c);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            hq[c].delete();
            in_stream[c] = 1'b0;
            prev_step[c] = 1'b0;
        end
    endtask

    task automatic check_model();
        for (int c = 0; c < 3; c++) begin
            logic [23:0] ed = '0;
            logic [2:0]  ev = '0;
            bit          any_v = 1'b0;
            ent_t        e;
            for (int i = 0; i < mm[c]; i++) begin
                e = at_d(c, (rv[c] != 0) ? (mm[c] - i) : (i + 1));
                ed[8*i +: 8] = e.dat[8*i +: 8];
                ev[i] = e.vld;
            end
            for (int d = 1; d <= mm[c]; d++) begin
                e = at_d(c, d);
                if (e.vld) any_v = 1'b1;
            end
            e = at_d(c, mm[c]);
            chk($sformatf("cfg%0d.out_data", c),  a_dat[c],  ed);
            chk($sformatf("cfg%0d.out_valid", c), a_vld[c],  ev);
            chk($sformatf("cfg%0d.out_done", c),  a_done[c], prev_step[c] && e.vld && e.last);
            chk($sformatf("cfg%0d.in_ready", c),  a_rdy[c],  exp_ready(c));
            chk($sformatf("cfg%0d.busy", c),      a_busy[c], in_stream[c] || draining(c) || any_v);
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            model_reset();
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (flush) begin
                    hq[c].delete();
                    in_stream[c] = 1'b0;
                    prev_step[c] = 1'b0;
                end else if (hold) begin
                    prev_step[c] = 1'b0;
                end else begin
                    ent_t e;
                    bit   f = in_valid && exp_ready(c);
                    e.dat  = f ? in_data : 24'h0;
                    e.vld  = f;
                    e.last = f && in_last;
                    hq[c].push_back(e);
                    if (hq[c].size() > 4) void'(hq[c].pop_front());
                    if (f) in_stream[c] = !in_last;
                    prev_step[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(bit f, bit h, bit v, bit l, logic [23:0] d);
        flush = f; hold = h; in_valid = v; in_last = l; in_data = d;
    endtask

    task automatic finish_cycle();
        check_model();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        @(negedge CLK);
        finish_cycle();
    endtask

    typedef struct {
        bit          v;
        bit          l;
        logic [23:0] d;
        logic [23:0] e_dat;
        logic [2:0]  e_ov;
        logic [23:0] e_rdat;
        logic [2:0]  e_rov;
        bit          e_done;
        bit          e_rdy;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 24'h030201, 24'h000000, 3'b000, 24'h000000, 3'b000, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 24'h131211, 24'h000001, 3'b001, 24'h030000, 3'b100, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 24'h232221, 24'h000211, 3'b011, 24'h130200, 3'b110, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 24'h000000, 24'h031221, 3'b111, 24'h231201, 3'b111, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 24'h000000, 24'h132200, 3'b110, 24'h002211, 3'b011, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 24'h000000, 24'h230000, 3'b100, 24'h000021, 3'b001, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 24'h000000, 3'b000, 1'b0, 1'b1};

        RST_N = 1'b0;
        drive(0, 0, 0, 0, 24'h0);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset.in_ready", rd0, 1'b1);
        chk("reset.busy", bz0, 1'b0);
        finish_cycle();
        tick();

        // Basic stream, both skew directions.
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, tbl[k].v, tbl[k].l, tbl[k].d);
            @(negedge CLK);
            chk($sformatf("tbl%0d.fwd_data", k),  od0, tbl[k].e_dat);
            chk($sformatf("tbl%0d.fwd_valid", k), ov0, tbl[k].e_ov);
            chk($sformatf("tbl%0d.rev_data", k),  od1, tbl[k].e_rdat);
            chk($sformatf("tbl%0d.rev_valid", k), ov1, tbl[k].e_rov);
            chk($sformatf("tbl%0d.fwd_done", k),  dn0, tbl[k].e_done);
            chk($sformatf("tbl%0d.rev_done", k),  dn1, tbl[k].e_done);
            chk($sformatf("tbl%0d.in_ready", k),  rd0, tbl[k].e_rdy);
            finish_cycle();
        end

        // Bubble walking diagonally.
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, (k == 0 || k == 2), (k == 2), 24'hA3A2A1 + 24'(k));
            @(negedge CLK);
            if (k == 2) chk("bubble.c2_valid", ov0, 3'b010);
            if (k == 2) chk("bubble.c2_l0", od0[7:0], 8'h00);
            if (k == 3) chk("bubble.c3_valid", ov0, 3'b101);
            if (k == 3) chk("bubble.c3_l1", od0[15:8], 8'h00);
            if (k == 4) chk("bubble.c4_valid", ov0, 3'b010);
            finish_cycle();
        end

        // Two-cycle hold entering drain: everything shifts by two.
        for (int k = 0; k < 9; k++) begin
            drive(0, (k == 3 || k == 4), (k < 3), (k == 2), 24'h030201 + 24'h101010 * 24'(k));
            @(negedge CLK);
            if (k == 4) chk("hold.frozen_c4", od0, 24'h031221);
            if (k == 5) chk("hold.frozen_c5", od0, 24'h031221);
            if (k == 5) chk("hold.no_done_c5", dn0, 1'b0);
            if (k == 6) chk("hold.data_c6", od0, 24'h132200);
            if (k == 7) chk("hold.done_c7", dn0, 1'b1);
            if (k == 8) chk("hold.done_c8", dn0, 1'b0);
            finish_cycle();
        end

        // Flush while draining.
        for (int k = 0; k < 8; k++) begin
            drive((k == 3), 0, (k < 3), (k == 2), 24'h030201 + 24'h101010 * 24'(k));
            @(negedge CLK);
            if (k == 3) chk("flush.in_ready", rd0, 1'b0);
            if (k == 4) chk("flush.valid", ov0, 3'b000);
            if (k == 4) chk("flush.data", od0, 24'h0);
            if (k == 4) chk("flush.busy", bz0, 1'b0);
            if (k == 5) chk("flush.no_done", dn0, 1'b0);
            finish_cycle();
        end

        // Single-vector last stream on the one-lane build.
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, (k == 0), 1'b1, 24'h00005A);
            @(negedge CLK);
            if (k == 1) chk("m1.done", dn2, 1'b1);
            if (k == 1) chk("m1.data", od2, 8'h5A);
            if (k == 2) chk("m1.done_once", dn2, 1'b0);
            finish_cycle();
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1'b1, 1'b0, 24'h445566 + 24'(k));
            if (k == 2) begin
                #2;
                RST_N = 1'b0;
                #1;
                chk("arst.data", od0, 24'h0);
                chk("arst.valid", ov0, 3'b000);
                chk("arst.rev_data", od1, 24'h0);
                chk("arst.done", dn0, 1'b0);
                chk("arst.busy", bz0, 1'b0);
                model_reset();
            end
            tick();
        end
        tick();
        RST_N = 1'b1;
        drive(0, 0, 0, 0, 24'h0);
        @(negedge CLK);
        chk("arst.release_ready", rd0, 1'b1);
        chk("arst.release_busy", bz0, 1'b0);
        finish_cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25, 24'($urandom));
            if ($urandom_range(0, 99) < 2) begin
                RST_N = 1'b0;
                model_reset();
            end else begin
                RST_N = 1'b1;
            end
            tick();
        end

        RST_N = 1'b1;
        drive(0, 0, 0, 0, 24'h0);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
